// File: rtl/pcs_rx_lane_deskew.sv
// rtl/pcs_rx_lane_deskew.sv - per-lane symbol FIFOs aligned on a common COM column
module pcs_rx_lane_deskew #(
  parameter int                   LANES      = 4,
  parameter int                   SYM_WIDTH  = 8,
  parameter int                   DEPTH      = 8,
  parameter int                   MAX_SKEW   = 4,
  parameter logic [SYM_WIDTH-1:0] COM_SYMBOL = 8'hBC
) (
  input  logic                            WordClk,
  input  logic                            Rst,
  input  logic                            Enable,
  input  logic [LANES*SYM_WIDTH-1:0]      Lane_Data,
  input  logic [LANES-1:0]                Lane_DataK,
  input  logic [LANES-1:0]                Lane_Valid,
  output logic [LANES*SYM_WIDTH-1:0]      Out_Data,
  output logic [LANES-1:0]                Out_DataK,
  output logic                            Out_Valid,
  output logic                            Deskewed,
  output logic [$clog2(MAX_SKEW+1)-1:0]   Skew_Observed,
  output logic                            Deskew_Error,
  output logic                            Overflow,
  output logic                            Align_Lost
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(MAX_SKEW + 2);
  localparam int SOW = $clog2(MAX_SKEW + 1);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [SYM_WIDTH-1:0]       mem_d  [LANES][DEPTH];
  logic [DEPTH-1:0]           mem_k  [LANES];
  logic [AW:0]                wr_ptr [LANES];
  logic [AW:0]                rd_ptr [LANES];

  logic [0:0]                 state;
  logic                       counting;
  logic [CW-1:0]              skew_cnt;
  logic [CW-1:0]              cur_cnt;

  logic [LANES-1:0]           empty;
  logic [LANES-1:0]           full;
  logic [LANES-1:0]           head_k;
  logic [LANES-1:0]           head_com;
  logic [LANES-1:0]           pop;
  logic [LANES-1:0]           wr_en;
  logic [LANES*SYM_WIDTH-1:0] head_data;
  logic                       all_nonempty;
  logic                       ovf_ev;
  logic                       lost_ev;
  logic                       err_ev;
  logic                       lock_ev;
  logic                       flush;

  assign Deskewed = (state == LOCKED);

  // Per-lane FIFO status and head decode; the extra pointer MSB separates full from empty
  always_comb begin
    empty     = '0;
    full      = '0;
    head_k    = '0;
    head_com  = '0;
    head_data = '0;
    for (int i = 0; i < LANES; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      head_data[i*SYM_WIDTH +: SYM_WIDTH] = mem_d[i][rd_ptr[i][AW-1:0]];
      head_k[i]   = mem_k[i][rd_ptr[i][AW-1:0]];
      head_com[i] = !empty[i] && head_k[i] &&
                    (mem_d[i][rd_ptr[i][AW-1:0]] == COM_SYMBOL);
    end
  end

  // Pop selection and event detection; a single flush covers every event source
  always_comb begin
    all_nonempty = ~|empty;
    cur_cnt      = counting ? skew_cnt : '0;
    pop          = '0;
    for (int i = 0; i < LANES; i++) begin
      // In SEARCH a lane parks on its COM head while the others catch up
      pop[i] = (state == LOCKED) ? all_nonempty : (!empty[i] && !head_com[i]);
    end
    ovf_ev  = Enable && (|(Lane_Valid & full & ~pop));
    lost_ev = Enable && (state == LOCKED) && all_nonempty &&
              (|head_com) && !(&head_com);
    err_ev  = Enable && (state == SEARCH) && (|head_com) && !(&head_com) &&
              (cur_cnt > CW'(MAX_SKEW));
    flush   = !Enable || ovf_ev || lost_ev || err_ev;
    lock_ev = !flush && (state == SEARCH) && (&head_com);
    wr_en   = flush ? '0 : (Lane_Valid & (~full | pop));
  end

  // Symbol storage; writes landing in a flush cycle are dropped by wr_en
  always_ff @(posedge WordClk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem_d[i][wr_ptr[i][AW-1:0]] <= Lane_Data[i*SYM_WIDTH +: SYM_WIDTH];
        mem_k[i][wr_ptr[i][AW-1:0]] <= Lane_DataK[i];
      end
    end
  end

  // FIFO pointers; flush empties every lane in one cycle
  always_ff @(posedge WordClk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (flush) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
        end else begin
          if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])   rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
      end
    end
  end

  // Alignment FSM, skew counter, registered output vector and prioritised pulses
  always_ff @(posedge WordClk or posedge Rst) begin
    if (Rst) begin
      state         <= SEARCH;
      counting      <= 1'b0;
      skew_cnt      <= '0;
      Skew_Observed <= '0;
      Out_Data      <= '0;
      Out_DataK     <= '0;
      Out_Valid     <= 1'b0;
      Overflow      <= 1'b0;
      Align_Lost    <= 1'b0;
      Deskew_Error  <= 1'b0;
    end else begin
      Overflow     <= ovf_ev;
      Align_Lost   <= lost_ev && !ovf_ev;
      Deskew_Error <= err_ev && !ovf_ev && !lost_ev;
      Out_Valid    <= 1'b0;
      if (flush) begin
        state    <= SEARCH;
        counting <= 1'b0;
        skew_cnt <= '0;
      end else if (state == LOCKED) begin
        if (all_nonempty) begin
          Out_Valid <= 1'b1;
          Out_Data  <= head_data;
          Out_DataK <= head_k;
        end
      end else if (lock_ev) begin
        state         <= LOCKED;
        Skew_Observed <= cur_cnt[SOW-1:0];
        counting      <= 1'b0;
        skew_cnt      <= '0;
      end else if (|head_com) begin
        // Bounded by the timeout check, so cur_cnt + 1 never exceeds MAX_SKEW + 1
        counting <= 1'b1;
        skew_cnt <= cur_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcs_rx_lane_deskew.sv
// tb/tb_pcs_rx_lane_deskew.sv - randomized bench with queue-based reference model
module tb_pcs_rx_lane_deskew;

  localparam int         L     = 4;
  localparam int         DEPTH = 8;
  localparam int         MAXS  = 4;
  localparam logic [7:0] COM   = 8'hBC;

  logic          WordClk;
  logic          Rst;
  logic          Enable;
  logic [L*8-1:0] Lane_Data;
  logic [L-1:0]  Lane_DataK;
  logic [L-1:0]  Lane_Valid;
  logic [L*8-1:0] Out_Data;
  logic [L-1:0]  Out_DataK;
  logic          Out_Valid;
  logic          Deskewed;
  logic [2:0]    Skew_Observed;
  logic          Deskew_Error;
  logic          Overflow;
  logic          Align_Lost;

  int errors = 0;
  int checks = 0;

  pcs_rx_lane_deskew dut (
    .WordClk(WordClk), .Rst(Rst), .Enable(Enable),
    .Lane_Data(Lane_Data), .Lane_DataK(Lane_DataK), .Lane_Valid(Lane_Valid),
    .Out_Data(Out_Data), .Out_DataK(Out_DataK), .Out_Valid(Out_Valid),
    .Deskewed(Deskewed), .Skew_Observed(Skew_Observed),
    .Deskew_Error(Deskew_Error), .Overflow(Overflow), .Align_Lost(Align_Lost)
  );

  initial WordClk = 1'b0;
  always #5 WordClk = ~WordClk;

  // Reference model: one queue of {K,data} per lane, skew measured in absolute cycles
  logic [8:0]  mq [L][$];
  bit          m_locked;
  int          m_cyc;
  int          m_first;
  logic [31:0] m_data;
  logic [3:0]  m_k;
  logic [2:0]  m_skew;
  bit          m_valid, m_err, m_ovf, m_lost;

  // Stimulus streams: lane i carries the shared symbol sequence starting at cycle st[i]
  int         st [L];
  int         idx [L];
  int         pc;
  logic [7:0] salt;
  int         drop_lane, drop_at, hold_lane, hold_from, hold_to;

  function automatic logic [8:0] sym(input int n);
    if (n % 16 == 0) return {1'b1, COM};
    return {1'b0, 8'(n * 37 + int'(salt))};
  endfunction

  function automatic logic [43:0] obs_vec();
    return {Out_Valid, Deskewed, Deskew_Error, Overflow, Align_Lost,
            Skew_Observed, Out_DataK, Out_Data};
  endfunction

  function automatic logic [43:0] exp_vec();
    return {m_valid, m_locked, m_err, m_ovf, m_lost, m_skew, m_k, m_data};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) mq[i].delete();
    m_locked = 0; m_first = -1; m_cyc = 0;
    m_data = '0; m_k = '0; m_skew = '0;
    m_valid = 0; m_err = 0; m_ovf = 0; m_lost = 0;
  endtask

  task automatic model_step();
    bit hc [L];
    bit pp [L];
    bit anyc, allc, alln, ovf, lost, err, flush;
    int cnt;
    anyc = 0; allc = 1; alln = 1;
    for (int i = 0; i < L; i++) begin
      hc[i] = (mq[i].size() > 0) && (mq[i][0] == {1'b1, COM});
      anyc |= hc[i];
      allc &= hc[i];
      alln &= (mq[i].size() > 0);
    end
    for (int i = 0; i < L; i++)
      pp[i] = m_locked ? alln : ((mq[i].size() > 0) && !hc[i]);
    ovf = 0;
    for (int i = 0; i < L; i++)
      if (mq[i].size() == DEPTH && Lane_Valid[i] && !pp[i]) ovf = 1;
    lost = m_locked && alln && anyc && !allc;
    if (!m_locked && anyc && m_first < 0) m_first = m_cyc;
    cnt = (m_first < 0) ? 0 : (m_cyc - m_first);
    err = !m_locked && anyc && !allc && (cnt > MAXS);
    m_valid = 0; m_err = 0; m_ovf = 0; m_lost = 0;
    flush = 1;
    if (!Enable) flush = 1;
    else if (ovf) m_ovf = 1;
    else if (lost) m_lost = 1;
    else if (err) m_err = 1;
    else flush = 0;
    if (flush) begin
      for (int i = 0; i < L; i++) mq[i].delete();
      m_locked = 0;
      m_first  = -1;
    end else begin
      if (m_locked && alln) begin
        m_valid = 1;
        for (int i = 0; i < L; i++) {m_k[i], m_data[i*8 +: 8]} = mq[i][0];
      end
      for (int i = 0; i < L; i++) if (pp[i]) void'(mq[i].pop_front());
      for (int i = 0; i < L; i++)
        if (Lane_Valid[i]) mq[i].push_back({Lane_DataK[i], Lane_Data[i*8 +: 8]});
      if (!m_locked && allc) begin
        m_locked = 1;
        m_skew   = 3'(cnt);
        m_first  = -1;
      end
    end
    m_cyc++;
  endtask

  task automatic phase_init(input int s0, input int s1, input int s2, input int s3);
    st[0] = s0; st[1] = s1; st[2] = s2; st[3] = s3;
    for (int i = 0; i < L; i++) idx[i] = 0;
    pc = 0;
    salt = 8'($urandom);
    drop_lane = -1; drop_at = -1; hold_lane = -1; hold_from = -1; hold_to = -1;
  endtask

  task automatic tick(input bit en);
    logic [8:0] s;
    @(negedge WordClk);
    Enable = en;
    for (int i = 0; i < L; i++) begin
      if (i == hold_lane && pc >= hold_from && pc < hold_to) begin
        Lane_Valid[i] = 1'b0;
        s = {1'b0, 8'($urandom)};
      end else begin
        Lane_Valid[i] = 1'b1;
        if (pc < st[i]) begin
          s = {1'b0, 8'($urandom)};
        end else begin
          if (i == drop_lane && pc == drop_at) idx[i]++;
          s = sym(idx[i]);
          idx[i]++;
        end
      end
      {Lane_DataK[i], Lane_Data[i*8 +: 8]} = s;
    end
    @(posedge WordClk);
    model_step();
    #1;
    pc++;
  endtask

  task automatic apply_reset();
    @(negedge WordClk);
    Rst = 1'b1; Enable = 1'b0; Lane_Valid = '0;
    @(negedge WordClk);
    model_reset();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Enable = 1'b0; Lane_Valid = '0; Lane_Data = '0; Lane_DataK = '0;
    @(negedge WordClk);
    @(negedge WordClk);
    checks++;
    if (obs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 44'h0);
    end
    model_reset();
    Rst = 1'b0;
    phase_init(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_zero_skew();
    apply_reset();
    phase_init(10, 10, 10, 10);
    for (int c = 0; c < 40; c++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL zero_skew cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 10) begin
        checks++;
        if (Deskewed !== 1'b0) begin
          errors++;
          $display("FAIL zero_skew_early_lock got=%b exp=0", Deskewed);
        end
      end
      if (c == 11) begin
        checks++;
        if ({Deskewed, Skew_Observed} !== {1'b1, 3'd0}) begin
          errors++;
          $display("FAIL zero_skew_lock got=%b/%0d exp=1/0", Deskewed, Skew_Observed);
        end
      end
      if (c == 12) begin
        checks++;
        if ({Out_Valid, Out_DataK, Out_Data} !== {1'b1, 4'hF, 32'hBCBCBCBC}) begin
          errors++;
          $display("FAIL zero_skew_com_column got=%b %h %h exp=1 f bcbcbcbc",
                   Out_Valid, Out_DataK, Out_Data);
        end
      end
    end
  endtask

  task automatic test_skew();
    apply_reset();
    phase_init(10, 11, 13, 12);
    for (int c = 0; c < 40; c++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL skew cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (Out_Valid === 1'b1) begin
        checks++;
        if (!(Out_Data[7:0] == Out_Data[15:8] && Out_Data[7:0] == Out_Data[23:16] &&
              Out_Data[7:0] == Out_Data[31:24] && (Out_DataK == 4'h0 || Out_DataK == 4'hF))) begin
          errors++;
          $display("FAIL skew_columns cyc=%0d got=%h/%h exp=identical", c, Out_DataK, Out_Data);
        end
      end
      if (c == 13 || c == 14) begin
        checks++;
        if (Deskewed !== (c == 14)) begin
          errors++;
          $display("FAIL skew_lock_time cyc=%0d got=%b exp=%b", c, Deskewed, c == 14);
        end
      end
    end
    checks++;
    if ({Deskewed, Skew_Observed} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL skew_observed got=%b/%0d exp=1/3", Deskewed, Skew_Observed);
    end
  endtask

  task automatic test_skew_timeout();
    apply_reset();
    phase_init(10, 10, 16, 10);
    for (int c = 0; c < 20; c++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 15 || c == 16) begin
        checks++;
        if (Deskew_Error !== (c == 16)) begin
          errors++;
          $display("FAIL timeout_pulse cyc=%0d got=%b exp=%b", c, Deskew_Error, c == 16);
        end
      end
    end
    phase_init(10, 10, 10, 10);
    for (int c = 0; c < 30; c++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_relock cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({Deskewed, Skew_Observed} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL timeout_relocked got=%b/%0d exp=1/0", Deskewed, Skew_Observed);
    end
  endtask

  task automatic test_align_lost();
    int lost_n;
    lost_n = 0;
    apply_reset();
    phase_init(10, 10, 10, 10);
    drop_lane = 1; drop_at = 20;
    for (int c = 0; c < 60; c++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL align_lost cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (Align_Lost === 1'b1) begin
        lost_n++;
        checks++;
        if ({Out_Valid, Deskewed} !== 2'b00) begin
          errors++;
          $display("FAIL align_lost_outputs cyc=%0d got=%b%b exp=00", c, Out_Valid, Deskewed);
        end
      end
    end
    checks++;
    if ({lost_n, Deskewed, Skew_Observed} !== {32'd1, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL align_lost_relock got=%0d/%b/%0d exp=1/1/1", lost_n, Deskewed, Skew_Observed);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    phase_init(10, 10, 10, 10);
    hold_lane = 0; hold_from = 20; hold_to = 27;
    for (int c = 0; c < 34; c++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_pop cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 28) begin
        checks++;
        if ({Out_Valid, Overflow} !== 2'b10) begin
          errors++;
          $display("FAIL full_pop_accept got=%b%b exp=10", Out_Valid, Overflow);
        end
      end
    end
    apply_reset();
    phase_init(10, 10, 10, 10);
    hold_lane = 0; hold_from = 20; hold_to = 40;
    for (int c = 0; c < 60; c++) begin
      tick(1'b1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (c == 27 || c == 28) begin
        checks++;
        if ({Overflow, Deskewed} !== ((c == 28) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL overflow_pulse cyc=%0d got=%b%b exp=%b", c, Overflow, Deskewed,
                   (c == 28) ? 2'b10 : 2'b01);
        end
      end
    end
  endtask

  task automatic test_async_reset_enable();
    apply_reset();
    phase_init(10, 10, 10, 10);
    for (int c = 0; c < 20; c++) tick(1'b1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset_locked got=%h exp=%h", obs_vec(), exp_vec());
    end
    @(negedge WordClk);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 44'h0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs_vec(), 44'h0);
    end
    model_reset();
    @(negedge WordClk);
    Rst = 1'b0;
    phase_init(5, 5, 5, 5);
    for (int c = 0; c < 30; c++) begin
      tick(1'b0);
      checks++;
      if (obs_vec() !== exp_vec() || {Deskewed, Out_Valid} !== 2'b00) begin
        errors++;
        $display("FAIL enable_low cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      phase_init(10 + $urandom_range(0, 4), 10 + $urandom_range(0, 4),
                 10 + $urandom_range(0, 4), 10 + $urandom_range(0, 4));
      hold_lane = $urandom_range(0, 3);
      hold_from = $urandom_range(15, 40);
      hold_to   = hold_from + $urandom_range(0, 10);
      drop_lane = $urandom_range(0, 3);
      drop_at   = $urandom_range(15, 60);
      for (int c = 0; c < 80; c++) begin
        tick($urandom_range(0, 39) != 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, c, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_skew();
    test_skew();
    test_skew_timeout();
    test_align_lost();
    test_overflow();
    test_async_reset_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
